// File: rtl/pic_ctl.sv
// pic_ctl: NIRQ-line edge-triggered interrupt controller with fixed-priority nesting.
// Optional PIC_SPECIFIC_EOI_EN adds a specific-EOI command and a +7 status read.
module pic_ctl #(
    parameter int          NIRQ       = 8,
    parameter logic [15:0] BASE_PORT  = 16'h0020,
    parameter logic [7:0]  VECT_RESET = 8'h08
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            port_clk,
    input  logic [15:0]     port,
    input  logic [7:0]      port_o,
    input  logic            port_w,
    output logic [7:0]      port_i,
    input  logic [NIRQ-1:0] irq_line,
    output logic            intr,
    output logic [7:0]      irq,
    input  logic            intr_latch
);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [NIRQ-1:0] irr_q, irr_d;
    logic [NIRQ-1:0] isr_q, isr_d;
    logic [NIRQ-1:0] imr_q, imr_d;
    logic [NIRQ-1:0] prev_q, prev_d;
    logic [7:0]      vbase_q, vbase_d;
    logic            intr_q, intr_d;
    logic [7:0]      irq_q, irq_d;
    logic [7:0]      port_i_q, port_i_d;

    logic [15:0] off;
    logic        wr_en, rd_en;
    logic [15:0] irr_w, isr_w, imr_w, req_w, imr_n;
    logic [15:0] eoi_w, dmask_w, low_isr;
    logic        cand_v, stop;
    logic [3:0]  cand_k;
`ifdef PIC_SPECIFIC_EOI_EN
    logic [3:0]  hi_idx;
`endif

    assign port_i = port_i_q;
    assign intr   = intr_q;
    assign irq    = irq_q;

    always_comb begin
        off   = port - BASE_PORT;
        rd_en = port_clk && (off[15:3] == 13'd0) && !port_w;
        wr_en = port_clk && (off[15:3] == 13'd0) && port_w;
        irr_w = 16'(irr_q);
        isr_w = 16'(isr_q);
        imr_w = 16'(imr_q);
        req_w = irr_w & ~imr_w;
        low_isr = isr_w & (~isr_w + 16'd1);

        // An in-service line blocks itself and every lower-priority line.
        cand_v = 1'b0;
        cand_k = 4'd0;
        stop   = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (!stop && !cand_v) begin
                if (isr_w[k]) begin
                    stop = 1'b1;
                end else if (req_w[k]) begin
                    cand_v = 1'b1;
                    cand_k = 4'(k);
                end
            end
        end

`ifdef PIC_SPECIFIC_EOI_EN
        hi_idx = 4'd0;
        for (int k = 0; k < 16; k++) begin
            if (isr_w[k]) hi_idx = 4'(k);
        end
`endif

        eoi_w = 16'd0;
        if (wr_en && off[2:0] == 3'd0) begin
`ifdef PIC_SPECIFIC_EOI_EN
            if (port_o[6:5] == 2'b11) begin
                eoi_w[port_o[3:0]] = 1'b1;
            end else if (port_o[6:5] == 2'b01) begin
                eoi_w = low_isr;
            end
`else
            if (port_o[5]) eoi_w = low_isr;
`endif
        end

        state_d = state_q;
        intr_d  = intr_q;
        irq_d   = irq_q;
        dmask_w = 16'd0;
        unique case (state_q)
            IDLE: begin
                if (cand_v) begin
                    dmask_w = 16'd1 << cand_k;
                    irq_d   = vbase_q + {4'd0, cand_k};
                    intr_d  = ~intr_latch;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (intr_q == intr_latch) state_d = IDLE;
            end
        endcase

        // A fresh edge wins over the delivery clear of the same bit.
        prev_d = irq_line;
        irr_d  = (irr_q & ~dmask_w[NIRQ-1:0]) | (irq_line & ~prev_q);
        isr_d  = (isr_q & ~eoi_w[NIRQ-1:0]) | dmask_w[NIRQ-1:0];

        imr_n   = imr_w;
        vbase_d = vbase_q;
        if (wr_en) begin
            case (off[2:0])
                3'd1:    imr_n[7:0]  = port_o;
                3'd2:    imr_n[15:8] = port_o;
                3'd3:    vbase_d     = port_o;
                default: ;
            endcase
        end
        imr_d = imr_n[NIRQ-1:0];

        port_i_d = port_i_q;
        if (rd_en) begin
            case (off[2:0])
                3'd0:    port_i_d = irr_w[7:0];
                3'd1:    port_i_d = imr_w[7:0];
                3'd2:    port_i_d = imr_w[15:8];
                3'd3:    port_i_d = vbase_q;
                3'd4:    port_i_d = isr_w[7:0];
                3'd5:    port_i_d = isr_w[15:8];
                3'd6:    port_i_d = irr_w[15:8];
`ifdef PIC_SPECIFIC_EOI_EN
                default: port_i_d = {state_q, 3'd0, hi_idx};
`else
                default: port_i_d = 8'd0;
`endif
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= IDLE;
            irr_q    <= '0;
            isr_q    <= '0;
            imr_q    <= '0;
            prev_q   <= '0;
            vbase_q  <= VECT_RESET;
            intr_q   <= 1'b0;
            irq_q    <= 8'd0;
            port_i_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            irr_q    <= irr_d;
            isr_q    <= isr_d;
            imr_q    <= imr_d;
            prev_q   <= prev_d;
            vbase_q  <= vbase_d;
            intr_q   <= intr_d;
            irq_q    <= irq_d;
            port_i_q <= port_i_d;
        end
    end

endmodule

// File: tb/tb_pic_ctl.sv
// Directed bench for pic_ctl: 8-line and 16-line instances, vector scoreboard
// checked whenever the 8-line instance toggles intr.
module tb_pic_ctl;

    localparam logic [15:0] BASE = 16'h0020;

    logic        clock = 1'b0;
    logic        resetn;
    logic        pc8, pc16;
    logic [15:0] port;
    logic [7:0]  port_o;
    logic        port_w;
    logic [7:0]  pi8, pi16;
    logic [7:0]  line8;
    logic [15:0] line16;
    logic        intr8, intr16, lat8, lat16;
    logic [7:0]  irq8, irq16;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];
    logic prev8;
    logic [7:0] d;

    always #5 clock = ~clock;

    pic_ctl #(.NIRQ(8)) u8 (
        .clock(clock), .resetn(resetn), .port_clk(pc8), .port(port),
        .port_o(port_o), .port_w(port_w), .port_i(pi8), .irq_line(line8),
        .intr(intr8), .irq(irq8), .intr_latch(lat8)
    );

    pic_ctl #(.NIRQ(16)) u16 (
        .clock(clock), .resetn(resetn), .port_clk(pc16), .port(port),
        .port_o(port_o), .port_w(port_w), .port_i(pi16), .irq_line(line16),
        .intr(intr16), .irq(irq16), .intr_latch(lat16)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every intr toggle must match the oldest expected vector.
    always @(negedge clock) begin
        if (resetn === 1'b1 && intr8 !== prev8) begin
            chk("sb_pending", 16'(exp_q.size() != 0), 16'd1);
            if (exp_q.size() != 0) chk("sb_vector", {8'h00, irq8}, {8'h00, exp_q.pop_front()});
        end
        prev8 = intr8;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic rd(input bit big, input logic [2:0] off, output logic [7:0] v);
        port = BASE + 16'(off);
        port_w = 1'b0;
        if (big) pc16 = 1'b1; else pc8 = 1'b1;
        tick();
        pc8 = 1'b0;
        pc16 = 1'b0;
        v = big ? pi16 : pi8;
    endtask

    task automatic wr(input bit big, input logic [2:0] off, input logic [7:0] v);
        port = BASE + 16'(off);
        port_o = v;
        port_w = 1'b1;
        if (big) pc16 = 1'b1; else pc8 = 1'b1;
        tick();
        pc8 = 1'b0;
        pc16 = 1'b0;
        port_w = 1'b0;
    endtask

    task automatic rdchk(input bit big, input logic [2:0] off, input logic [7:0] e, input string tag);
        logic [7:0] v;
        rd(big, off, v);
        chk(tag, {8'h00, v}, {8'h00, e});
    endtask

    task automatic wait8(input int max, input string tag);
        int n = 0;
        while (intr8 === lat8 && n < max) begin
            tick();
            n++;
        end
        chk(tag, 16'(intr8 !== lat8), 16'd1);
    endtask

    task automatic ack8();
        lat8 = intr8;
        tick();
    endtask

    task automatic eoi8();
        wr(1'b0, 3'd0, 8'h20);
    endtask

    task automatic pulse8(input logic [7:0] m);
        line8 = m;
        tick();
        line8 = 8'h00;
    endtask

    initial begin
        resetn = 1'b0;
        pc8 = 1'b0; pc16 = 1'b0; port = 16'h0; port_o = 8'h0; port_w = 1'b0;
        line8 = 8'h0; line16 = 16'h0; lat8 = 1'b0; lat16 = 1'b0;
        repeat (3) tick();
        chk("rst_intr", {15'd0, intr8}, 16'd0);
        chk("rst_irq", {8'h00, irq8}, 16'd0);
        chk("rst_port_i", {8'h00, pi8}, 16'd0);
        resetn = 1'b1;
        tick();
        rdchk(1'b0, 3'd3, 8'h08, "rst_vbase");
        rdchk(1'b0, 3'd1, 8'h00, "rst_imr");

        // Single edge on line 0: toggle exactly two cycles after the edge.
        exp_q.push_back(8'h08);
        pulse8(8'h01);
        chk("t1_early", {15'd0, intr8}, 16'd0);
        tick();
        chk("t1_intr", {15'd0, intr8}, 16'd1);
        chk("t1_irq", {8'h00, irq8}, 16'h0008);
        rdchk(1'b0, 3'd4, 8'h01, "t1_isr");
        ack8();
        eoi8();
        rdchk(1'b0, 3'd4, 8'h00, "t1_isr_eoi");

        // Masked line 1 stays pending while line 3 is delivered.
        wr(1'b0, 3'd1, 8'h02);
        exp_q.push_back(8'h0B);
        pulse8(8'h0A);
        wait8(4, "t2_deliver");
        rdchk(1'b0, 3'd0, 8'h02, "t2_irr");
        ack8();
        eoi8();
        rdchk(1'b0, 3'd4, 8'h00, "t2_isr");
        exp_q.push_back(8'h09);
        wr(1'b0, 3'd1, 8'h00);
        wait8(4, "t2_unmask");
        ack8();
        eoi8();

        // Held-high line triggers once only.
        exp_q.push_back(8'h08);
        line8 = 8'h01;
        tick();
        wait8(4, "hold_deliver");
        ack8();
        eoi8();
        repeat (10) tick();
        line8 = 8'h00;
        rdchk(1'b0, 3'd0, 8'h00, "hold_irr");

        // Edge arriving with the delivery clear of the same bit keeps IRR set.
        wr(1'b0, 3'd1, 8'h01);
        pulse8(8'h01);
        tick();
        rdchk(1'b0, 3'd0, 8'h01, "sw_masked_irr");
        chk("sw_no_deliver", {15'd0, intr8}, {15'd0, lat8});
        exp_q.push_back(8'h08);
        exp_q.push_back(8'h08);
        wr(1'b0, 3'd1, 8'h00);
        line8 = 8'h01;
        tick();
        line8 = 8'h00;
        chk("sw_toggle", 16'(intr8 !== lat8), 16'd1);
        rdchk(1'b0, 3'd0, 8'h01, "sw_irr_kept");
        ack8();
        eoi8();
        wait8(4, "sw_second");
        ack8();
        eoi8();
        rdchk(1'b0, 3'd4, 8'h00, "sw_isr");

        // Nesting: 3 then 1, line 5 held off until both EOIs.
        exp_q.push_back(8'h0B);
        pulse8(8'h08);
        wait8(4, "nest_3");
        ack8();
        exp_q.push_back(8'h09);
        pulse8(8'h02);
        wait8(4, "nest_1");
        ack8();
        pulse8(8'h20);
        repeat (5) tick();
        chk("nest_blocked", {15'd0, intr8}, {15'd0, lat8});
        rdchk(1'b0, 3'd4, 8'h0A, "nest_isr");
        rdchk(1'b0, 3'd0, 8'h20, "nest_irr");
        eoi8();
        repeat (3) tick();
        rdchk(1'b0, 3'd4, 8'h08, "nest_isr_eoi1");
        exp_q.push_back(8'h0D);
        eoi8();
        wait8(4, "nest_5");
        chk("nest_5_irq", {8'h00, irq8}, 16'h000D);
        ack8();
        eoi8();
        rdchk(1'b0, 3'd4, 8'h00, "nest_isr_end");

        // EOI and delivery on the same edge both apply.
        exp_q.push_back(8'h0B);
        pulse8(8'h08);
        wait8(4, "ed_3");
        ack8();
        exp_q.push_back(8'h09);
        line8 = 8'h02;
        tick();
        line8 = 8'h00;
        port = BASE;
        port_o = 8'h20;
        port_w = 1'b1;
        pc8 = 1'b1;
        tick();
        pc8 = 1'b0;
        port_w = 1'b0;
        chk("ed_toggle", 16'(intr8 !== lat8), 16'd1);
        rdchk(1'b0, 3'd4, 8'h02, "ed_isr");
        ack8();
        eoi8();
        eoi8();
        rdchk(1'b0, 3'd4, 8'h00, "ed_empty_eoi");

        // Command 8'h63 with ISR=0A.
        exp_q.push_back(8'h0B);
        pulse8(8'h08);
        wait8(4, "se_3");
        ack8();
        exp_q.push_back(8'h09);
        pulse8(8'h02);
        wait8(4, "se_1");
        ack8();
        wr(1'b0, 3'd0, 8'h63);
`ifdef PIC_SPECIFIC_EOI_EN
        rdchk(1'b0, 3'd4, 8'h02, "se_isr");
`else
        rdchk(1'b0, 3'd4, 8'h08, "se_isr");
`endif
        eoi8();
        eoi8();
        rdchk(1'b0, 3'd4, 8'h00, "se_isr_end");

        // No ack for 100 cycles: only one toggle, line 2 first.
        exp_q.push_back(8'h0A);
        pulse8(8'h14);
        wait8(4, "na_2");
        repeat (100) tick();
        rdchk(1'b0, 3'd0, 8'h10, "na_irr");
        exp_q.push_back(8'h0C);
        ack8();
        eoi8();
        wait8(4, "na_4");
        chk("na_4_irq", {8'h00, irq8}, 16'h000C);
        ack8();
        eoi8();

        // Register width and decode boundaries.
        wr(1'b0, 3'd2, 8'hFF);
        rdchk(1'b0, 3'd2, 8'h00, "hi_imr");
        rdchk(1'b0, 3'd5, 8'h00, "hi_isr");
        rdchk(1'b0, 3'd6, 8'h00, "hi_irr");
`ifndef PIC_SPECIFIC_EOI_EN
        rdchk(1'b0, 3'd7, 8'h00, "off7");
`endif
        wr(1'b0, 3'd3, 8'h40);
        rdchk(1'b0, 3'd3, 8'h40, "vbase_rw");
        port = BASE + 16'd8;
        port_w = 1'b0;
        pc8 = 1'b1;
        tick();
        pc8 = 1'b0;
        chk("unmatched", {8'h00, pi8}, 16'h0040);

        // 16-line instance: vector wraps past 8'hFF.
        wr(1'b1, 3'd3, 8'hF8);
        line16 = 16'h1000;
        tick();
        line16 = 16'h0000;
        tick();
        chk("w16_intr", 16'(intr16 !== lat16), 16'd1);
        chk("w16_irq", {8'h00, irq16}, 16'h0004);
        rdchk(1'b1, 3'd5, 8'h10, "w16_isr_hi");
        rdchk(1'b1, 3'd4, 8'h00, "w16_isr_lo");
        lat16 = intr16;
        tick();

        // Reset during WAIT drops pending and in-service state.
        exp_q.push_back(8'h40);
        pulse8(8'h01);
        wait8(4, "rw_deliver");
        pulse8(8'h20);
        tick();
        resetn = 1'b0;
        lat8 = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
        chk("rw_intr", {15'd0, intr8}, 16'd0);
        chk("rw_irq", {8'h00, irq8}, 16'd0);
        rdchk(1'b0, 3'd0, 8'h00, "rw_irr");
        rdchk(1'b0, 3'd4, 8'h00, "rw_isr");
        rdchk(1'b0, 3'd3, 8'h08, "rw_vbase");
        repeat (4) tick();
        chk("sb_empty", 16'(exp_q.size()), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
